spi_oversample_rx: RTL and testbench

Parametrised, self-calibrating SPI receiver that runs entirely in the CLK_40 domain and oversamples an external SPI_clk, SPI_cs_n and LANES data lines. On request it measures the SPI_clk period, places the sample point at mid-bit after each falling (launch) edge, deserialises WORD_W bits per lane and buffers the words in a show-ahead FIFO with a valid/ready output. It sits between the board SPI pins and the frame-buffer write path. It replaces the fixed single-lane calibration/sampling path with measured-period sampling, multi-lane capture, chip-select framing and overflow reporting.

---
 rtl/spi_oversample_rx_if.sv | 34 +++
 rtl/spi_oversample_rx.sv | 240 ++++++++++++++++++++++++
 tb/tb_spi_oversample_rx.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_oversample_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_oversample_rx_if
// Brief    : Output stream bundle of the oversampling SPI receiver (FIFO head,
//            valid/ready handshake, full and sticky overflow flags).
// Revision : 1.0 - initial release
// ============================================================================
interface spi_oversample_rx_if #(
  parameter int LANES  = 1,
  parameter int WORD_W = 8
);
  logic [LANES*WORD_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    fifo_full;
  logic                    overflow;

  modport master (
    output out_data,
    output out_valid,
    output fifo_full,
    output overflow,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  fifo_full,
    input  overflow,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/spi_oversample_rx.sv
`default_nettype none
// ============================================================================
// Module   : spi_oversample_rx
// Brief    : Self-calibrating oversampling SPI receiver: measures SPI_clk period,
//            samples LANES data lines at mid-bit, buffers words in a FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module spi_oversample_rx #(
  parameter int LANES       = 1,
  parameter int WORD_W      = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int CAL_EDGES   = 4,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLK_40,
  input  logic                 reset,
  input  logic                 SPI_clk,
  input  logic                 SPI_cs_n,
  input  logic [LANES-1:0]     data_in,
  input  logic                 phase_cal_en,
  output logic                 cal_done,
  output logic                 cal_error,
  output logic [CNT_W-1:0]     period,
  output logic [CNT_W-1:0]     sample_offset,
  spi_oversample_rx_if.master  out_if
);

  localparam int LOG2_CAL = $clog2(CAL_EDGES);
  localparam int SUM_W    = CNT_W + LOG2_CAL;
  localparam int EDGE_W   = LOG2_CAL + 1;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int BIT_W    = $clog2(WORD_W);
  localparam int DATA_W   = LANES * WORD_W;
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_MEASURE = 3'd1;
  localparam logic [2:0] S_COMPUTE = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_ERROR   = 3'd4;

  // Identical synchroniser chains keep clock, select and data aligned.
  logic [SYNC_STAGES-1:0]            r_clk_sync;
  logic [SYNC_STAGES-1:0]            r_cs_sync;
  logic [SYNC_STAGES-1:0][LANES-1:0] r_dat_sync;
  logic                              r_clk_prev;
  logic                              r_fall;
  logic                              w_clk;
  logic                              w_cs_n;
  logic [LANES-1:0]                  w_dat;

  assign w_clk  = r_clk_sync[SYNC_STAGES-1];
  assign w_cs_n = r_cs_sync[SYNC_STAGES-1];
  assign w_dat  = r_dat_sync[SYNC_STAGES-1];

  always_ff @(posedge CLK_40) begin
    if (reset) begin
      r_clk_sync <= '0;
      r_cs_sync  <= '1;
      r_dat_sync <= '0;
      r_clk_prev <= 1'b0;
      r_fall     <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], SPI_clk};
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], SPI_cs_n};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], data_in};
      r_clk_prev <= w_clk;
      r_fall     <= r_clk_prev & ~w_clk;
    end
  end

  // Calibration FSM
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_per_cnt;
  logic             r_armed;
  logic [EDGE_W-1:0] r_edges;
  logic [SUM_W-1:0] r_sum;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_offset;
  logic [CNT_W-1:0] w_avg;
  logic [CNT_W-1:0] w_half;

  assign w_avg  = CNT_W'(r_sum >> LOG2_CAL);
  assign w_half = w_avg >> 1;

  always_ff @(posedge CLK_40) begin
    if (reset || !phase_cal_en) begin
      r_state   <= S_IDLE;
      r_per_cnt <= '0;
      r_armed   <= 1'b0;
      r_edges   <= '0;
      r_sum     <= '0;
      r_period  <= '0;
      r_offset  <= '0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_MEASURE;
        S_MEASURE: begin
          // Saturation doubles as the no-clock timeout, armed or not.
          if (r_per_cnt == C_CNT_MAX) begin
            r_state <= S_ERROR;
          end else if (r_fall) begin
            r_per_cnt <= CNT_W'(1);
            r_armed   <= 1'b1;
            if (r_armed) begin
              if (r_per_cnt < CNT_W'(4)) begin
                r_state <= S_ERROR;
              end else begin
                r_sum   <= r_sum + SUM_W'(r_per_cnt);
                r_edges <= r_edges + EDGE_W'(1);
                if (r_edges == EDGE_W'(CAL_EDGES - 1)) r_state <= S_COMPUTE;
              end
            end
          end else begin
            r_per_cnt <= r_per_cnt + CNT_W'(1);
          end
        end
        S_COMPUTE: begin
          r_period <= w_avg;
          r_offset <= (w_half == '0) ? CNT_W'(1) : w_half;
          r_state  <= S_RUN;
        end
        S_RUN:   r_state <= S_RUN;
        S_ERROR: r_state <= S_ERROR;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cal_done      = (r_state == S_RUN);
  assign cal_error     = (r_state == S_ERROR);
  assign period        = r_period;
  assign sample_offset = r_offset;

  // Mid-bit sampling and deserialisation
  logic [CNT_W-1:0]                r_off_cnt;
  logic                            r_pending;
  logic [BIT_W-1:0]                r_bit_cnt;
  logic [LANES-1:0][WORD_W-1:0]    r_shift;
  logic [LANES-1:0][WORD_W-1:0]    w_shift_nxt;
  logic                            r_push;
  logic [DATA_W-1:0]               r_push_word;
  logic                            w_sample;
  logic                            w_last;

  assign w_sample = (r_state == S_RUN) && !w_cs_n && r_pending &&
                    (r_off_cnt == r_offset - CNT_W'(1));
  assign w_last   = (r_bit_cnt == BIT_W'(WORD_W - 1));

  always_comb begin
    w_shift_nxt = r_shift;
    for (int k = 0; k < LANES; k++) begin
      w_shift_nxt[k] = {r_shift[k][WORD_W-2:0], w_dat[k]};
    end
  end

  always_ff @(posedge CLK_40) begin
    if (reset || (r_state != S_RUN) || w_cs_n) begin
      r_off_cnt <= '0;
      r_pending <= 1'b0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      if (r_fall) begin
        r_off_cnt <= '0;
        r_pending <= 1'b1;
      end else if (w_sample) begin
        r_pending <= 1'b0;
      end else if (r_pending) begin
        r_off_cnt <= r_off_cnt + CNT_W'(1);
      end
      if (w_sample) begin
        r_shift   <= w_shift_nxt;
        r_bit_cnt <= w_last ? '0 : r_bit_cnt + BIT_W'(1);
      end
    end
  end

  // The completed word is captured at the last sample so a following
  // chip-select release cannot corrupt it before the push.
  always_ff @(posedge CLK_40) begin
    if (reset) begin
      r_push      <= 1'b0;
      r_push_word <= '0;
    end else begin
      r_push <= w_sample && w_last;
      if (w_sample && w_last) r_push_word <= w_shift_nxt;
    end
  end

  // Show-ahead FIFO
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr;
  logic [PTR_W-1:0]  r_rd;
  logic [PTR_W:0]    r_count;
  logic              r_ovf;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push_ok;

  assign w_full    = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pop     = !w_empty && out_if.out_ready;
  assign w_push_ok = r_push && (!w_full || w_pop);

  always_ff @(posedge CLK_40) begin
    if (w_push_ok) r_mem[r_wr] <= r_push_word;
  end

  always_ff @(posedge CLK_40) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + PTR_W'(1);
      if (w_pop)     r_rd <= r_rd + PTR_W'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
      if (r_push && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end else if ((r_state == S_IDLE) && phase_cal_en) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign out_if.out_valid = !w_empty;
  assign out_if.out_data  = w_empty ? '0 : r_mem[r_rd];
  assign out_if.fifo_full = w_full;
  assign out_if.overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_spi_oversample_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_oversample_rx
// Brief    : Directed self-checking bench for spi_oversample_rx (LANES=2,
//            lane 1 carries the inverse of lane 0) with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_oversample_rx;
  localparam int LANES = 2;
  localparam int WORD_W = 8;
  localparam int DEPTH = 16;
  localparam int CNT_W = 8;
  localparam int HALF = 10;

  logic clk = 1'b0;
  logic rst;
  logic sclk, cs_n, cal_en;
  logic [LANES-1:0] din;
  logic cal_done, cal_error;
  logic [CNT_W-1:0] period, offset;

  spi_oversample_rx_if #(.LANES(LANES), .WORD_W(WORD_W)) bus ();

  spi_oversample_rx #(
    .LANES(LANES), .WORD_W(WORD_W), .FIFO_DEPTH(DEPTH),
    .CAL_EDGES(4), .CNT_W(CNT_W), .SYNC_STAGES(2)
  ) dut (
    .CLK_40(clk), .reset(rst), .SPI_clk(sclk), .SPI_cs_n(cs_n),
    .data_in(din), .phase_cal_en(cal_en), .cal_done(cal_done),
    .cal_error(cal_error), .period(period), .sample_offset(offset),
    .out_if(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_pops = 0;
  logic [15:0] exp_q[$];
  logic exp_ovf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Lane 0 carries the byte, lane 1 its inverse; lane 1 sits in the upper bits.
  function automatic logic [15:0] lane_word(input logic [7:0] b);
    return {~b, b};
  endfunction

  // FIFO rule: accepted if room, or if a pop happens in the same cycle.
  task automatic model_push(input logic [7:0] b, input bit pop_same);
    if (exp_q.size() < DEPTH || pop_same) exp_q.push_back(lane_word(b));
    else exp_ovf = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      n_pops++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pop_unexpected: got 0x%0h, expected no word", bus.out_data);
      end else begin
        check("pop_data", {16'h0, bus.out_data}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    sclk = 1'b0;
    din  = {~b, b};
  endtask

  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      drive_bit(w[i]);
      tick(HALF);
      sclk = 1'b1;
      tick(HALF);
    end
  endtask

  task automatic send_word(input logic [7:0] w, input bit pop_same);
    for (int i = 7; i >= 0; i--) begin
      drive_bit(w[i]);
      if (i == 0) model_push(w, pop_same);
      tick(HALF);
      sclk = 1'b1;
      tick(HALF);
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.out_valid && n < 40) begin
      tick(1);
      n++;
    end
    check("wait_valid", {31'h0, bus.out_valid}, 32'h1);
  endtask

  task automatic pop_one();
    bus.out_ready = 1'b1;
    tick(1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_f, lat, pops0;
    logic [7:0] w;
    rst = 1'b1; sclk = 1'b1; cs_n = 1'b1; din = '0; cal_en = 1'b0;
    bus.out_ready = 1'b0;
    tick(3);
    check("rst_cal_done", {31'h0, cal_done}, 0);
    check("rst_cal_error", {31'h0, cal_error}, 0);
    check("rst_period", {24'h0, period}, 0);
    check("rst_offset", {24'h0, offset}, 0);
    check("rst_valid", {31'h0, bus.out_valid}, 0);
    check("rst_data", {16'h0, bus.out_data}, 0);
    check("rst_full", {31'h0, bus.fifo_full}, 0);
    check("rst_overflow", {31'h0, bus.overflow}, 0);
    rst = 1'b0;
    tick(2);

    // Calibration at a 20-cycle SPI period: first fall arms, four periods follow.
    cal_en = 1'b1;
    tick(3);
    done_f = 0;
    for (int f = 1; f <= 10 && done_f == 0; f++) begin
      tick(HALF);
      sclk = 1'b0;
      repeat (HALF) begin
        tick(1);
        if (cal_done && done_f == 0) done_f = f;
      end
      sclk = 1'b1;
    end
    tick(HALF);
    check("cal_falls_to_done", done_f, 5);
    check("cal_done", {31'h0, cal_done}, 1);
    check("cal_period", {24'h0, period}, 20);
    check("cal_offset", {24'h0, offset}, 10);

    // 0xA5: sync(2)+pulse reg(1)+offset(10)+push(1)+count(1) -> valid 15 cycles
    // after the last fall is driven, i.e. on the 16th negedge counted from it.
    cs_n = 1'b0;
    tick(4);
    w = 8'hA5;
    send_bits(w, 7);
    drive_bit(w[0]);
    model_push(w, 1'b0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 40);
    check("word_latency", lat, 16);
    @(posedge clk);
    #1;
    sclk = 1'b1;
    tick(HALF);
    check("word_a5_literal", {16'h0, bus.out_data}, 32'h5AA5);
    pop_one();
    send_word(8'h3C, 1'b0);
    wait_valid();
    check("word_3c_literal", {16'h0, bus.out_data}, 32'hC33C);
    pop_one();

    // Chip-select release after 5 bits discards the partial word.
    send_bits(8'hFF, 5);
    cs_n = 1'b1;
    tick(6);
    cs_n = 1'b0;
    tick(6);
    send_word(8'h81, 1'b0);
    wait_valid();
    check("word_81_literal", {16'h0, bus.out_data}, 32'h7E81);
    pop_one();
    tick(3);
    check("empty_after_81", {31'h0, bus.out_valid}, 0);

    // Fill to full, then push+pop at full, then one dropped word.
    for (int n = 0; n < DEPTH; n++) send_word(8'(n * 17 + 3), 1'b0);
    tick(4);
    check("full_after_16", {31'h0, bus.fifo_full}, 1);
    check("no_ovf_at_16", {31'h0, bus.overflow}, 0);
    pops0 = n_pops;
    fork
      send_word(8'hE7, 1'b1);
      begin
        // Last fall driven 140 cycles in; its push lands 14 cycles later.
        tick(7 * 2 * HALF + 14);
        bus.out_ready = 1'b1;
        tick(1);
        bus.out_ready = 1'b0;
      end
    join
    tick(4);
    check("simul_pop_count", n_pops - pops0, 1);
    check("simul_no_ovf", {31'h0, bus.overflow}, 0);
    check("simul_still_full", {31'h0, bus.fifo_full}, 1);
    send_word(8'h42, 1'b0);
    tick(4);
    check("overflow_set", {31'h0, bus.overflow}, {31'h0, exp_ovf});
    check("overflow_literal", {31'h0, bus.overflow}, 1);
    pops0 = n_pops;
    bus.out_ready = 1'b1;
    tick(30);
    bus.out_ready = 1'b0;
    check("drain_count", n_pops - pops0, 16);
    check("drain_empty", {31'h0, bus.out_valid}, 0);
    check("drain_not_full", {31'h0, bus.fifo_full}, 0);

    // Reset in RUN with three words queued.
    for (int n = 0; n < 3; n++) send_word(8'(8'h11 * (n + 1)), 1'b0);
    tick(4);
    check("queued_valid", {31'h0, bus.out_valid}, 1);
    rst = 1'b1;
    tick(1);
    exp_q.delete();
    check("rrun_cal_done", {31'h0, cal_done}, 0);
    check("rrun_period", {24'h0, period}, 0);
    check("rrun_offset", {24'h0, offset}, 0);
    check("rrun_valid", {31'h0, bus.out_valid}, 0);
    check("rrun_data", {16'h0, bus.out_data}, 0);
    check("rrun_full", {31'h0, bus.fifo_full}, 0);
    check("rrun_overflow", {31'h0, bus.overflow}, 0);
    cal_en = 1'b0;
    cs_n = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(3);

    // A 3-cycle SPI period is too short to sample reliably.
    cal_en = 1'b1;
    tick(3);
    for (int f = 0; f < 20 && !cal_error; f++) begin
      sclk = 1'b1;
      tick(1);
      sclk = 1'b0;
      tick(2);
    end
    sclk = 1'b1;
    check("err_cal_error", {31'h0, cal_error}, 1);
    check("err_cal_done", {31'h0, cal_done}, 0);
    check("err_period", {24'h0, period}, 0);
    cal_en = 1'b0;
    tick(1);
    check("err_cleared", {31'h0, cal_error}, 0);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
